// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int BUF_DEPTH = 2;

  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic {
    IF_IDLE = 1'b0,
    IF_WAIT = 1'b1
  } if_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry FIFO of fetch entries with clear
module fetch_buffer
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         clear,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;

  // Storage and pointers; clear empties the queue and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM, next-PC mux and instruction queue
module instr_fetch_unit
  import riscv_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset_N,
  input  logic [XLEN-1:0] Pc_In,
  output logic [XLEN-1:0] Pc_Next,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  output logic            Imem_Req,
  output logic [XLEN-1:0] Imem_Addr,
  input  logic            Imem_Ack,
  input  logic [XLEN-1:0] Imem_Rdata,
  output logic            If_Valid,
  output logic [XLEN-1:0] If_Instr,
  output logic [XLEN-1:0] If_Pc,
  output logic            If_Err,
  input  logic            Id_Ready
);

  if_state_t       state;
  if_state_t       state_next;
  logic            drop;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            outstanding;
  logic            acked;
  logic            ack_push;
  logic            pop;
  logic            misaligned;
  logic [2:0]      occupancy;
  logic            room;
  logic            issue;
  logic            issue_mem;
  logic            issue_err;
  logic            push;

  assign outstanding = (state == IF_WAIT);
  assign acked       = outstanding & Imem_Ack;
  assign pop         = If_Valid & Id_Ready;
  assign misaligned  = |Pc_In[1:0];

  // An outstanding, non-dropped request already owns a queue slot whether or
  // not it is acked this cycle, so the queue can never be pushed while full.
  assign occupancy = {1'b0, count} + {2'b0, outstanding & ~drop} - {2'b0, pop};
  assign room      = (occupancy < 3'd2);

  assign ack_push  = acked & ~drop & ~Branch_Taken;
  // A misaligned fault push never shares a cycle with a memory-data push.
  assign issue     = Reset_N & room & ~Branch_Taken & (~outstanding | Imem_Ack)
                   & ~(misaligned & ack_push);
  assign issue_mem = issue & ~misaligned;
  assign issue_err = issue & misaligned;
  assign push      = ack_push | issue_err;

  // State register; reset drops any in-flight request immediately.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IF_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, next PC and the entry to enqueue.
  always_comb begin
    state_next = state;
    Pc_Next    = Pc_In;
    push_entry = '{instr: Imem_Rdata, pc: addr_q, err: 1'b0};
    case (state)
      IF_IDLE: if (issue_mem) state_next = IF_WAIT;
      IF_WAIT: if (Imem_Ack) state_next = issue_mem ? IF_WAIT : IF_IDLE;
      default: state_next = IF_IDLE;
    endcase
    if (issue_err) begin
      push_entry = '{instr: '0, pc: Pc_In, err: 1'b1};
    end
    if (!Reset_N) begin
      Pc_Next = Pc_In;
    end else if (Branch_Taken) begin
      Pc_Next = Branch_Target;
    end else if (issue) begin
      Pc_Next = Pc_In + PC_INCR;
    end
  end

  // Request address and the drop flag for a request orphaned by a flush.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      addr_q <= '0;
      drop   <= 1'b0;
    end else begin
      if (issue_mem) begin
        addr_q <= Pc_In;
      end
      if (Branch_Taken && outstanding && !Imem_Ack) begin
        drop <= 1'b1;
      end else if (acked) begin
        drop <= 1'b0;
      end
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk        (Clk),
    .rst_n      (Reset_N),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (Branch_Taken),
    .count      (count),
    .head       (head)
  );

  assign Imem_Req  = outstanding;
  assign Imem_Addr = addr_q;
  assign If_Valid  = (count != 2'd0);
  assign If_Instr  = head.instr;
  assign If_Pc     = head.pc;
  assign If_Err    = head.err;

endmodule
